// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU fetch/execute sequencer: FSM states,
// the HALT sentinel and the instruction field positions.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } seq_state_t;

  localparam int WORD_W   = 16;
  localparam int NUM_REGS = 8;

  localparam logic [WORD_W-1:0] HALT_WORD = 16'hFFFF;

  localparam int IA_LSB = 8;
  localparam int IB_LSB = 4;
  localparam int IDX_W  = 3;

  // RA register index carried in an instruction word
  function automatic logic [IDX_W-1:0] field_ia(input logic [WORD_W-1:0] ins);
    return ins[IA_LSB +: IDX_W];
  endfunction

  // RB register index carried in an instruction word
  function automatic logic [IDX_W-1:0] field_ib(input logic [WORD_W-1:0] ins);
    return ins[IB_LSB +: IDX_W];
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// 8x16 register file: two operand read ports, a host read port and two
// write ports. When both write ports hit the same entry the B port wins.
module seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_a_addr,
  output logic [WORD_W-1:0] rd_a_data,
  input  logic [IDX_W-1:0]  rd_b_addr,
  output logic [WORD_W-1:0] rd_b_data,
  input  logic [IDX_W-1:0]  host_addr,
  output logic [WORD_W-1:0] host_rdata,
  input  logic              we_a,
  input  logic [IDX_W-1:0]  wa_addr,
  input  logic [WORD_W-1:0] wa_data,
  input  logic              we_b,
  input  logic [IDX_W-1:0]  wb_addr,
  input  logic [WORD_W-1:0] wb_data
);

  logic [WORD_W-1:0] rf [NUM_REGS];

  logic a_blocked;
  assign a_blocked = we_b && (wa_addr == wb_addr);

  assign rd_a_data  = rf[rd_a_addr];
  assign rd_b_data  = rf[rd_b_addr];
  assign host_rdata = rf[host_addr];

  // Register storage; A write is suppressed on an index collision so B wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (we_a && !a_blocked) begin
        rf[wa_addr] <= wa_data;
      end
      if (we_b) begin
        rf[wb_addr] <= wb_data;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute controller in front of a combinational two-operand ALU.
// Fetches 16-bit words over req/ack, presents registered operands and the
// raw instruction to the ALU, and writes both ALU results back.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  input  logic              host_we,
  input  logic [2:0]        host_addr,
  input  logic [15:0]       host_wdata,
  output logic [15:0]       host_rdata,
  output logic [15:0]       alu_ra,
  output logic [15:0]       alu_rb,
  output logic [15:0]       alu_ins,
  input  logic [15:0]       alu_ra_res,
  input  logic [15:0]       alu_rb_res
);

  seq_state_t        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [WORD_W-1:0] ir_q;
  logic              busy_q;
  logic              done_q;
  logic              req_q;
  logic [WORD_W-1:0] alu_ra_q;
  logic [WORD_W-1:0] alu_rb_q;
  logic [WORD_W-1:0] alu_ins_q;

  // Operand reads are indexed by the word arriving from memory so the
  // operands can be registered on the ack edge and be stable for EXEC.
  logic [IDX_W-1:0]  fetch_ia;
  logic [IDX_W-1:0]  fetch_ib;
  logic [WORD_W-1:0] rd_a_data;
  logic [WORD_W-1:0] rd_b_data;

  logic [IDX_W-1:0]  ir_ia;
  logic [IDX_W-1:0]  ir_ib;

  logic              we_a;
  logic              we_b;
  logic [IDX_W-1:0]  wb_addr;
  logic [WORD_W-1:0] wb_data;

  assign fetch_ia = field_ia(imem_data);
  assign fetch_ib = field_ib(imem_data);
  assign ir_ia    = field_ia(ir_q);
  assign ir_ib    = field_ib(ir_q);

  assign busy      = busy_q;
  assign done      = done_q;
  assign pc        = pc_q;
  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign alu_ra    = alu_ra_q;
  assign alu_rb    = alu_rb_q;
  assign alu_ins   = alu_ins_q;

  // Write-port steering: host writes share the B port while idle,
  // ALU results use both ports in writeback
  always_comb begin
    we_a    = 1'b0;
    we_b    = 1'b0;
    wb_addr = ir_ib;
    wb_data = alu_rb_res;
    case (state_q)
      ST_IDLE: begin
        we_b    = host_we;
        wb_addr = host_addr;
        wb_data = host_wdata;
      end
      ST_WB: begin
        we_a = (ir_ia != ir_ib);
        we_b = 1'b1;
      end
      default: ;
    endcase
  end

  seq_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_a_addr  (fetch_ia),
    .rd_a_data  (rd_a_data),
    .rd_b_addr  (fetch_ib),
    .rd_b_data  (rd_b_data),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .we_a       (we_a),
    .wa_addr    (ir_ia),
    .wa_data    (alu_ra_res),
    .we_b       (we_b),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  // Sequencer FSM with registered control outputs and ALU operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      alu_ra_q  <= '0;
      alu_rb_q  <= '0;
      alu_ins_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir_q  <= imem_data;
            req_q <= 1'b0;
            if (imem_data == HALT_WORD) begin
              // HALT never reaches the ALU; operand registers keep their values
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_EXEC;
              alu_ra_q  <= rd_a_data;
              alu_rb_q  <= rd_b_data;
              alu_ins_q <= imem_data;
            end
          end
        end
        ST_EXEC: begin
          state_q <= ST_WB;
        end
        ST_WB: begin
          pc_q    <= pc_q + 1'b1;
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
